dma_burst_arbiter: RTL

//  Multi-channel DMA burst controller: successor to the single-channel go/dma_req/data_transfer

---
 rtl/dma_burst_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dma_burst_arbiter.sv
// Multi-channel DMA burst controller: per-channel request capture with round-robin
// grant, one burst in flight at a time, back-pressure honoured through xfer_ready.
module dma_burst_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 256,
    parameter int LEN_W     = $clog2(MAX_BURST + 1),
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       go,
    input  logic [NUM_CH-1:0]       dma_req,
    input  logic [NUM_CH*LEN_W-1:0] burst_len,
    input  logic                    xfer_ready,
    output logic                    data_transfer,
    output logic [CH_W-1:0]         xfer_ch,
    output logic [LEN_W-1:0]        beats_left,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       err,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BURST);
    localparam logic [CH_W:0]    NUM_CH_E = (CH_W + 1)'(NUM_CH);

    state_t              state_reg, state_next;
    logic [NUM_CH-1:0]   go_q_reg;
    logic [NUM_CH-1:0]   pending_reg, pending_next;
    logic [NUM_CH-1:0]   err_reg;
    logic [LEN_W-1:0]    len_reg [NUM_CH];
    logic [LEN_W-1:0]    count_reg, count_next;
    logic [CH_W-1:0]     ch_reg, ch_next;
    logic [CH_W-1:0]     rr_reg, rr_next;

    logic [LEN_W-1:0]    len_in   [NUM_CH];
    logic [LEN_W-1:0]    cand_len [NUM_CH];
    logic [NUM_CH-1:0]   new_req, accept, reject, cand;
    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W:0]       idx_sum;
    logic [CH_W:0]       rr_inc;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic bad_len;
        logic in_use;

        assign len_in[gi]  = burst_len[gi*LEN_W +: LEN_W];
        assign new_req[gi] = go[gi] & ~go_q_reg[gi] & dma_req[gi];
        assign bad_len     = (len_in[gi] == '0) || (len_in[gi] > MAX_LEN);
        assign in_use      = pending_reg[gi] || ((state_reg == S_XFER) && (ch_reg == CH_W'(gi)));
        assign accept[gi]  = new_req[gi] & ~bad_len & ~in_use;
        assign reject[gi]  = new_req[gi] & (bad_len | in_use);
        // A request accepted on the grant edge itself has no stored length yet.
        assign cand_len[gi] = pending_reg[gi] ? len_reg[gi] : len_in[gi];
    end

    // Round-robin search: first candidate at or after the pointer, wrapping.
    always_comb begin
        cand        = pending_reg | accept;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_sum     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_sum = {1'b0, rr_reg} + (CH_W + 1)'(k);
            if (idx_sum >= NUM_CH_E) begin
                idx_sum = idx_sum - NUM_CH_E;
            end
            if (!grant_found && cand[idx_sum[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_sum[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        ch_next      = ch_reg;
        rr_next      = rr_reg;
        pending_next = pending_reg | accept;
        rr_inc       = {1'b0, grant_idx} + (CH_W + 1)'(1);
        if (rr_inc >= NUM_CH_E) begin
            rr_inc = '0;
        end
        case (state_reg)
            S_IDLE: begin
                if (grant_found) begin
                    state_next              = S_XFER;
                    count_next              = cand_len[grant_idx];
                    ch_next                 = grant_idx;
                    rr_next                 = rr_inc[CH_W-1:0];
                    pending_next[grant_idx] = 1'b0;
                end
            end
            S_XFER: begin
                if (xfer_ready) begin
                    if (count_reg == LEN_W'(1)) begin
                        state_next = S_DONE;
                    end else begin
                        count_next = count_reg - LEN_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            go_q_reg    <= '0;
            pending_reg <= '0;
            err_reg     <= '0;
            count_reg   <= '0;
            ch_reg      <= '0;
            rr_reg      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                len_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            go_q_reg    <= go;
            pending_reg <= pending_next;
            err_reg     <= reject;
            count_reg   <= count_next;
            ch_reg      <= ch_next;
            rr_reg      <= rr_next;
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    len_reg[i] <= len_in[i];
                end
            end
        end
    end

    assign data_transfer = (state_reg == S_XFER);
    assign xfer_ch       = ch_reg;
    assign beats_left    = data_transfer ? count_reg : '0;
    assign done          = (state_reg == S_DONE) ? (NUM_CH'(1) << ch_reg) : '0;
    assign err           = err_reg;
    assign busy          = (state_reg != S_IDLE) || (|pending_reg);

endmodule
